// File: rtl/ext_pipe.sv
// ext_pipe: registered width-extension stage (zero/sign/upper/sign+shift)
// with valid/ready handshake, output register and one-entry skid buffer.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               input handshake
//   in_data[IN_W], in_mode[2]       field and extension mode
//   in_tag[TAG_W]                   sideband tag
//   out_valid/out_ready             output handshake
//   out_data[OUT_W], out_tag[TAG_W] extended word and its tag
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t           state;
   logic [OUT_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic [OUT_W-1:0] zx;
   logic [OUT_W-1:0] sx;
   logic [OUT_W-1:0] ext;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Upper placement shifts the zero-extended field, which keeps the low
   // OUT_W bits even when OUT_W < 2*IN_W.
   always_comb begin
      zx  = {{(OUT_W-IN_W){1'b0}}, in_data};
      sx  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      ext = zx;
      unique case (in_mode)
         2'b00: ext = zx;
         2'b01: ext = sx;
         2'b10: ext = zx << (OUT_W - IN_W);
         2'b11: ext = sx << SHIFT;
         default: ext = zx;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         skid_data <= '0;
         skid_tag  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  out_data  <= ext;
                  out_tag   <= in_tag;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  out_data <= ext;
                  out_tag  <= in_tag;
               end else if (in_fire) begin
                  // consumer stalled: park the new word, stop accepting
                  skid_data <= ext;
                  skid_tag  <= in_tag;
                  in_ready  <= 1'b0;
                  state     <= TWO;
               end else if (out_fire) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  out_data <= skid_data;
                  out_tag  <= skid_tag;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and scoreboarded checks of ext_pipe
// (default 16->32 instance plus an 8->16, SHIFT=1 instance).
module tb_ext_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        v8;
   logic        r8;
   logic [7:0]  d8;
   logic [1:0]  m8;
   logic [4:0]  t8;
   logic        ov8;
   logic        or8;
   logic [15:0] od8;
   logic [4:0]  ot8;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ext_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   ext_pipe #(.IN_W(8), .OUT_W(16), .SHIFT(1), .TAG_W(5)) u8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8), .in_ready(r8),
      .in_data(d8), .in_mode(m8), .in_tag(t8),
      .out_valid(ov8), .out_ready(or8),
      .out_data(od8), .out_tag(ot8)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref16(input logic [15:0] d,
                                         input logic [1:0] m);
      logic [31:0] s;
      s = {{16{d[15]}}, d};
      case (m)
         2'd0:    return {16'h0, d};
         2'd1:    return s;
         2'd2:    return {d, 16'h0};
         default: return s << 2;
      endcase
   endfunction

   task automatic one(input logic [15:0] d, input logic [1:0] m,
                      input logic [4:0] t, input logic [31:0] exp,
                      input string nm);
      @(negedge clk);
      check({nm, "_idle"}, out_valid, 0);
      check({nm, "_rdy"}, in_ready, 1);
      in_valid = 1; in_data = d; in_mode = m; in_tag = t;
      @(negedge clk);
      in_valid = 0;
      check({nm, "_vld"}, out_valid, 1);
      check(nm, out_data, exp);
      check({nm, "_tag"}, out_tag, t);
   endtask

   logic [63:0] q[$];
   int          sent;
   int          rcvd;
   int          cyc;
   logic        acc;

   initial begin
      rst_n = 0; in_valid = 0; in_data = 0; in_mode = 0; in_tag = 0;
      out_ready = 1;
      v8 = 0; d8 = 0; m8 = 0; t8 = 0; or8 = 1;
      #12;
      check("rst_vld", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_tag", out_tag, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("rel_rdy", in_ready, 1);

      one(16'h8001, 2'b00, 5'd1, 32'h00008001, "m00");
      one(16'h8001, 2'b01, 5'd2, 32'hFFFF8001, "m01");
      one(16'h8001, 2'b10, 5'd3, 32'h80010000, "m10");
      one(16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC, "m11n");
      one(16'h0004, 2'b11, 5'd5, 32'h00000010, "m11p");

      // streaming, 8 back-to-back words
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("str_rdy", in_ready, 1);
         if (i > 0) begin
            check("str_vld", out_valid, 1);
            check("str_tag", out_tag, i - 1);
            check("str_data", out_data, i * 3);
         end
         in_valid = 1; in_data = 16'(i * 3 + 3); in_mode = 0;
         in_tag = 5'(i);
      end
      @(negedge clk);
      in_valid = 0;
      check("str_last_tag", out_tag, 7);
      check("str_last_data", out_data, 24);

      // backpressure
      @(negedge clk);
      check("bp_idle", out_valid, 0);
      out_ready = 0;
      in_valid = 1; in_data = 16'h1234; in_mode = 0; in_tag = 1;
      @(negedge clk);
      check("bp_a_vld", out_valid, 1);
      check("bp_a_data", out_data, 32'h00001234);
      check("bp_rdy1", in_ready, 1);
      in_data = 16'h8000; in_mode = 1; in_tag = 2;
      @(negedge clk);
      check("bp_rdy0", in_ready, 0);
      in_data = 16'h0055; in_mode = 2; in_tag = 3;
      repeat (3) begin
         @(negedge clk);
         check("bp_hold_data", out_data, 32'h00001234);
         check("bp_hold_tag", out_tag, 1);
         check("bp_hold_rdy", in_ready, 0);
      end
      out_ready = 1;
      @(negedge clk);
      check("bp_b_data", out_data, 32'hFFFF8000);
      check("bp_b_tag", out_tag, 2);
      check("bp_b_rdy", in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      check("bp_c_data", out_data, 32'h00550000);
      check("bp_c_tag", out_tag, 3);
      @(negedge clk);
      check("bp_drain", out_valid, 0);

      // random backpressure, scoreboard against ref16
      sent = 0; rcvd = 0; cyc = 0; acc = 0;
      while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc) in_valid = 0;
         acc = 0;
         if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
            in_valid = 1;
            in_data = 16'($urandom);
            in_mode = 2'($urandom_range(0, 3));
            in_tag = 5'(sent);
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            rcvd++;
            if (q.size() == 0) check("rnd_extra", 1, 0);
            else check("rnd_word", {out_tag, out_data}, q.pop_front());
         end
         if (in_valid && in_ready) begin
            q.push_back({in_tag, ref16(in_data, in_mode)});
            sent++;
            acc = 1;
         end
      end
      check("rnd_timeout", cyc < 20000, 1);
      check("rnd_count", rcvd, 1000);
      @(negedge clk);
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      check("rnd_idle", out_valid, 0);

      // reset while holding two words
      out_ready = 0;
      in_valid = 1; in_data = 16'h0001; in_mode = 0; in_tag = 4;
      @(negedge clk);
      in_data = 16'h0002; in_tag = 5;
      @(negedge clk);
      in_valid = 0;
      check("two_rdy", in_ready, 0);
      check("two_vld", out_valid, 1);
      #2 rst_n = 0;
      #1;
      check("arst_vld", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_tag", out_tag, 0);
      @(negedge clk);
      rst_n = 1; out_ready = 1;
      @(negedge clk);
      check("arel_rdy", in_ready, 1);
      one(16'h0007, 2'b01, 5'd9, 32'h00000007, "post_rst");

      // 8 -> 16 instance, SHIFT = 1
      @(negedge clk);
      v8 = 1; d8 = 8'h80; m8 = 2'b11; t8 = 5'd6;
      @(negedge clk);
      check("p8_m11", od8, 16'hFF00);
      check("p8_m11_tag", ot8, 6);
      d8 = 8'hAB; m8 = 2'b10; t8 = 5'd7;
      @(negedge clk);
      v8 = 0;
      check("p8_m10", od8, 16'hAB00);
      check("p8_m10_vld", ov8, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, registered width-extension stage for the datapath. It converts an IN_W-bit field to an OUT_W-bit word in one of four modes: zero-extend, sign-extend, upper-place (LUI style) and sign-extend-then-shift (branch offset). A valid/ready handshake, one output register and a one-entry skid buffer let it sit between decode and execute with full throughput under backpressure. A sideband tag travels with each word.

Parameters:
IN_W, 16, input field width (>=2)
OUT_W, 32, output word width; must satisfy OUT_W >= IN_W+SHIFT
SHIFT, 2, left-shift amount applied in mode 2'b11
TAG_W, 5, sideband tag width (e.g. destination register index)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  block can accept input this cycle
in_data  in  IN_W  field to extend
in_mode  in  2  00 zero, 01 sign, 10 upper, 11 sign+shift
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  output word present
out_ready  in  1  consumer accepts output this cycle
out_data  out  OUT_W  extended word
out_tag  out  TAG_W  tag associated with out_data

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_tag=0, skid empty. in_ready=1 from the first cycle after release.
- Transfer rule: a transfer happens on a rising edge where valid&&ready. Data and tag are sampled only on an input transfer.
- Mode 00: out = {(OUT_W-IN_W){0}, in_data}.
- Mode 01: out = {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
- Mode 10: out = {in_data, (OUT_W-IN_W){0}} when OUT_W >= 2*IN_W. Otherwise it is the low OUT_W bits of in_data << (OUT_W-IN_W).
- Mode 11: out = sign-extended value << SHIFT. No bits are lost, given the OUT_W constraint.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- in_ready = ~skid_full. It is registered and does not depend combinationally on out_ready.
- States: EMPTY (out_valid=0), ONE (output register full), TWO (output register and skid full).
- EMPTY: an input transfer loads the output register -> ONE.
- ONE, output transfer, no input transfer -> EMPTY.
- ONE, input transfer, no output transfer -> the new word goes to skid -> TWO.
- ONE, input and output transfer together -> the new word replaces the output register -> stays ONE.
- TWO: in_ready=0. An output transfer moves skid to the output register -> ONE.
- Ordering: strictly FIFO. A word is never dropped or duplicated.
- out_data/out_tag hold stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: all held words are discarded immediately (asynchronously) and the outputs take their reset values.

Test Plan:
- Mode coverage (IN_W=16, OUT_W=32, SHIFT=2), out_ready=1:
  - in_data=0x8001: mode 00 -> 0x00008001; mode 01 -> 0xFFFF8001; mode 10 -> 0x80010000.
  - Mode 11 with 0xFFFF -> 0xFFFFFFFC; with 0x0004 -> 0x00000010.
  - Each appears exactly 1 cycle after its transfer.
- Streaming: in_valid=1 for 8 cycles, tags 0..7, out_ready=1 -> 8 consecutive outputs, tags 0..7 in order, in_ready stays 1.
- Backpressure:
  - out_ready=0; present A (tag 1), B (tag 2), C (tag 3).
  - A and B are accepted; in_ready drops to 0 after B; C is held by the source.
  - Raise out_ready -> A, B, C emerge in order, and out_data stays stable during the stall.
- Simultaneous in/out transfer in ONE, with random out_ready at 50% over 1000 words -> no loss, no reorder, scoreboard matches the reference model.
- Reset: assert rst_n=0 while in TWO -> out_valid=0, out_data=0 in the same cycle. After release in_ready=1, and the next word passes through correctly.
- Parameter sweep: IN_W=8, OUT_W=16, SHIFT=1, mode 11 with 0x80 -> 0xFF00; mode 10 with 0xAB -> 0xAB00.
